stack_lifo: RTL and testbench

- Hardware LIFO (call/data stack) for the FRANK6000 datapath.
- Complements the write-only Register: data pushed by the writer is read back, in reverse order, through a registered read port.
- Sits between the control unit (push/pop strobes) and the data bus; used for subroutine return addresses and operand save/restore.

---
 rtl/stack_lifo.sv | 99 +++++++++
 tb/tb_stack_lifo.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/stack_lifo.sv
// Hardware LIFO with a registered pop port, sticky overflow/underflow flags and a push+pop replace-top operation.
// Define STACK_LIFO_PEEK_EN to add the combinational o_top peek output.
module stack_lifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_D,
    output logic [WIDTH-1:0] or_Q,
`ifdef STACK_LIFO_PEEK_EN
    output logic [WIDTH-1:0] o_top,
`endif
    output logic             o_empty,
    output logic             o_full,
    output logic [AW:0]      o_count,
    output logic             or_overflow,
    output logic             or_underflow
);

    localparam logic [AW:0] SP_ONE  = (AW+1)'(1);
    localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_sp;

    logic [AW:0]      w_sp_m1;
    logic [AW-1:0]    w_top_idx;
    logic [AW-1:0]    w_wr_idx;
    logic             w_empty;
    logic             w_full;

    // Top-of-stack index is sp-1; only meaningful when not empty.
    assign w_sp_m1   = r_sp - SP_ONE;
    assign w_top_idx = w_sp_m1[AW-1:0];
    assign w_wr_idx  = r_sp[AW-1:0];
    assign w_empty   = (r_sp == '0);
    assign w_full    = (r_sp == SP_FULL);

    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_count = r_sp;

`ifdef STACK_LIFO_PEEK_EN
    assign o_top = w_empty ? '0 : r_mem[w_top_idx];
`endif

    // Storage has no reset; a reset cycle suppresses any write in flight.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (i_push && !i_pop && !w_full) begin
                r_mem[w_wr_idx] <= i_D;
            end else if (i_push && i_pop && !w_empty) begin
                r_mem[w_top_idx] <= i_D;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sp         <= '0;
            or_Q         <= '0;
            or_overflow  <= 1'b0;
            or_underflow <= 1'b0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (!w_full) begin
                        r_sp <= r_sp + SP_ONE;
                    end else begin
                        or_overflow <= 1'b1;
                    end
                end
                2'b01: begin
                    if (!w_empty) begin
                        or_Q <= r_mem[w_top_idx];
                        r_sp <= w_sp_m1;
                    end else begin
                        or_underflow <= 1'b1;
                    end
                end
                2'b11: begin
                    // Replace-top when occupied; straight bypass when empty.
                    if (!w_empty) begin
                        or_Q <= r_mem[w_top_idx];
                    end else begin
                        or_Q <= i_D;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_lifo.sv
// Directed bench for stack_lifo (WIDTH=8, DEPTH=4); checks the peek port when STACK_LIFO_PEEK_EN is defined.
module tb_stack_lifo;

    logic       i_clk;
    logic       i_rst;
    logic       i_push;
    logic       i_pop;
    logic [7:0] i_D;
    logic [7:0] or_Q;
`ifdef STACK_LIFO_PEEK_EN
    logic [7:0] o_top;
`endif
    logic       o_empty;
    logic       o_full;
    logic [2:0] o_count;
    logic       or_overflow;
    logic       or_underflow;

    int n_checks = 0;
    int n_errors = 0;

    stack_lifo #(.WIDTH(8), .DEPTH(4)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_push       (i_push),
        .i_pop        (i_pop),
        .i_D          (i_D),
        .or_Q         (or_Q),
`ifdef STACK_LIFO_PEEK_EN
        .o_top        (o_top),
`endif
        .o_empty      (o_empty),
        .o_full       (o_full),
        .o_count      (o_count),
        .or_overflow  (or_overflow),
        .or_underflow (or_underflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic op(input logic push, input logic pop, input logic [7:0] d, input logic rst = 1'b0);
        i_push = push;
        i_pop  = pop;
        i_D    = d;
        i_rst  = rst;
        @(posedge i_clk);
        #1;
        i_push = 1'b0;
        i_pop  = 1'b0;
        i_D    = 8'h00;
        i_rst  = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic [7:0] q, input logic [2:0] cnt,
                             input logic emp, input logic ful, input logic ovf, input logic unf);
        chk({tag, ".q"},     {24'h0, or_Q}, {24'h0, q});
        chk({tag, ".count"}, {29'h0, o_count}, {29'h0, cnt});
        chk({tag, ".empty"}, {31'h0, o_empty}, {31'h0, emp});
        chk({tag, ".full"},  {31'h0, o_full}, {31'h0, ful});
        chk({tag, ".ovf"},   {31'h0, or_overflow}, {31'h0, ovf});
        chk({tag, ".unf"},   {31'h0, or_underflow}, {31'h0, unf});
    endtask

    initial begin
        i_rst = 1'b1; i_push = 1'b0; i_pop = 1'b0; i_D = 8'h00;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;

        // Build some prior state (data, popped value, underflow flag), then reset.
        op(1, 0, 8'hAA);
        op(0, 1, 8'h00);
        op(0, 1, 8'h00);
        chk_state("pre_rst", 8'hAA, 3'd0, 1, 0, 0, 1);
        op(0, 0, 8'h00, 1'b1);
        chk_state("reset", 8'h00, 3'd0, 1, 0, 0, 0);
`ifdef STACK_LIFO_PEEK_EN
        chk("peek_empty", {24'h0, o_top}, 32'h0);
`endif

        // Fill.
        op(1, 0, 8'h11); chk("fill1.count", {29'h0, o_count}, 32'd1);
        op(1, 0, 8'h22); chk("fill2.count", {29'h0, o_count}, 32'd2);
        op(1, 0, 8'h33); chk("fill3.count", {29'h0, o_count}, 32'd3);
        op(1, 0, 8'h44);
        chk_state("full", 8'h00, 3'd4, 0, 1, 0, 0);
`ifdef STACK_LIFO_PEEK_EN
        chk("peek_full", {24'h0, o_top}, 32'h44);
`endif

        // Overflow must not disturb the top.
        op(1, 0, 8'h55);
        chk_state("ovf", 8'h00, 3'd4, 0, 1, 1, 0);

        // Drain.
        op(0, 1, 8'h00); chk_state("pop1", 8'h44, 3'd3, 0, 0, 1, 0);
        op(0, 1, 8'h00); chk_state("pop2", 8'h33, 3'd2, 0, 0, 1, 0);
        op(0, 1, 8'h00); chk_state("pop3", 8'h22, 3'd1, 0, 0, 1, 0);
        op(0, 1, 8'h00); chk_state("pop4", 8'h11, 3'd0, 1, 0, 1, 0);

        // Underflow holds or_Q; flags stay sticky across idle cycles.
        op(0, 1, 8'h00); chk_state("unf", 8'h11, 3'd0, 1, 0, 1, 1);
        op(0, 0, 8'h00); chk_state("idle", 8'h11, 3'd0, 1, 0, 1, 1);
        op(0, 0, 8'h00, 1'b1);
        chk_state("reset2", 8'h00, 3'd0, 1, 0, 0, 0);

        // Replace-top with two entries.
        op(1, 0, 8'hA1);
        op(1, 0, 8'hB2);
        op(1, 1, 8'hC3); chk_state("repl", 8'hB2, 3'd2, 0, 0, 0, 0);
        op(0, 1, 8'h00); chk_state("repl_pop1", 8'hC3, 3'd1, 0, 0, 0, 0);
        op(0, 1, 8'h00); chk_state("repl_pop2", 8'hA1, 3'd0, 1, 0, 0, 0);

        // Empty bypass sets no flag.
        op(1, 1, 8'h7E); chk_state("bypass", 8'h7E, 3'd0, 1, 0, 0, 0);

        // Replace-top while full does not overflow.
        op(1, 0, 8'h01);
        op(1, 0, 8'h02);
        op(1, 0, 8'h03);
        op(1, 0, 8'h04);
        op(1, 1, 8'h66); chk_state("repl_full", 8'h04, 3'd4, 0, 1, 0, 0);
        op(0, 1, 8'h00); chk_state("repl_full_pop1", 8'h66, 3'd3, 0, 0, 0, 0);
        op(0, 1, 8'h00); chk_state("repl_full_pop2", 8'h03, 3'd2, 0, 0, 0, 0);

        // Reset wins over a concurrent push.
        op(1, 0, 8'h12);
        op(1, 0, 8'h34);
        chk("pre_midrst.count", {29'h0, o_count}, 32'd4);
        op(1, 0, 8'h99, 1'b1);
        chk_state("midrst", 8'h00, 3'd0, 1, 0, 0, 0);
        op(0, 1, 8'h00);
        chk_state("midrst_pop", 8'h00, 3'd0, 1, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
